// File: rtl/uart_msg_pkg.sv
// Shared constants, state type and helpers for the UART message checker.
// MSG is indexed from 0 at the first transmitted byte.
package uart_msg_pkg;

  localparam int MSG_LEN = 16;
  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  localparam logic [0:MSG_LEN-1][7:0] MSG = "Metron UART ok!\n";

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE,
    TIMEOUT
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_msg_if.sv
// Byte stream in, checker status out.
// master drives bytes and clear; slave is the checker.
interface uart_msg_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       clear;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic       overrun;
  logic [7:0] err_count;
  logic [7:0] rx_count;
  logic [7:0] checksum;

  modport master (
    output in_data, in_valid, clear,
    input  busy, done, pass, timeout, overrun,
    input  err_count, rx_count, checksum
  );

  modport slave (
    input  in_data, in_valid, clear,
    output busy, done, pass, timeout, overrun,
    output err_count, rx_count, checksum
  );

endinterface

// File: rtl/uart_msg_rom.sv
// Expected-message lookup: index in, byte out, purely combinational.
// Out-of-range indices read as zero.
module uart_msg_rom
  import uart_msg_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       data
);

  assign data = (int'(idx) < MSG_LEN) ? MSG[idx] : 8'h00;

endmodule

// File: rtl/uart_msg_check.sv
// Checks a received UART byte stream against the fixed message MSG,
// with inter-byte timeout, mismatch count, checksum and overrun flag.
module uart_msg_check
  import uart_msg_pkg::*;
#(
  parameter int timeout_cycles = 1024
) (
  input logic       clk,
  input logic       rst,
  uart_msg_if.slave bus
);

  localparam int GAP_W = $clog2(timeout_cycles) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(timeout_cycles - 1);

  state_t           state;
  logic [GAP_W-1:0] gap;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic             overrun;
  logic [7:0]       err_count;
  logic [7:0]       rx_count;
  logic [7:0]       checksum;
  logic [7:0]       exp_byte;
  logic [7:0]       rx_next;
  logic [7:0]       err_next;
  logic             last;

  uart_msg_rom u_rom (
    .idx  (rx_count[IDX_W-1:0]),
    .data (exp_byte)
  );

  assign rx_next  = rx_count + 8'd1;
  assign last     = (rx_next == 8'(MSG_LEN));
  assign err_next = (bus.in_data == exp_byte)
                  ? err_count : sat_inc(err_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gap       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
      rx_count  <= '0;
      checksum  <= '0;
    end else if (bus.clear) begin
      state     <= IDLE;
      gap       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
      rx_count  <= '0;
      checksum  <= '0;
    end else begin
      unique case (state)
        IDLE, RECV: begin
          if (bus.in_valid) begin
            rx_count  <= rx_next;
            err_count <= err_next;
            checksum  <= checksum + bus.in_data;
            gap       <= '0;
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 8'd0);
            end else begin
              state <= RECV;
              busy  <= 1'b1;
            end
          end else if (state == RECV) begin
            // A byte on the threshold cycle wins over the timeout.
            if (gap == GAP_LAST) begin
              state   <= TIMEOUT;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b1;
            end else begin
              gap <= gap + 1'b1;
            end
          end
        end
        DONE, TIMEOUT: begin
          if (bus.in_valid) overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.timeout   = timeout;
  assign bus.overrun   = overrun;
  assign bus.err_count = err_count;
  assign bus.rx_count  = rx_count;
  assign bus.checksum  = checksum;

endmodule
